sobel_window_sequencer: RTL and testbench
=========================================

SOBEL_WINDOW_SEQUENCER -- requirements
Module: sobel_window_sequencer

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd24, the custom-instruction number this block answers to.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  custom-instruction start strobe from the CPU.
REQ-005 SHALL have port iseId  input  8  custom-instruction number; the block responds only when iseId == customInstructionId.
REQ-006 SHALL have port valueA  input  32  command word: [31:30] opcode, [1:0] row index.
REQ-007 SHALL have port valueB  input  32  operand: 4 pixels, byte 0 = leftmost pixel.
REQ-008 SHALL have port done  output  1  one-cycle completion strobe.
REQ-009 SHALL have port result  output  32  result word, valid only while done = 1, otherwise 32'd0.

Function
REQ-010 SHALL accept a command only when start = 1, iseId matches and the state is IDLE; other start pulses SHALL be ignored.
REQ-011 SHALL hold a window of 3 rows x 8 pixels; each row is an old word (pixels 0..3) and a cur word (pixels 4..7).
REQ-012 Opcode 00 LOAD: row r = valueA[1:0] SHALL shift so that old <= cur and cur <= valueB; done and result 0 SHALL follow 1 cycle after the accept.
REQ-013 LOAD with r = 3 SHALL change no buffer and still complete with done and result 0.
REQ-014 Opcode 01 COMPUTE SHALL produce 4 outputs k = 0..3, each centred at pixel c = 3+k, using columns c-1..c+1 of rows 0..2.
REQ-015 For each output: Gx = (p0[c+1]+2*p1[c+1]+p2[c+1]) - (p0[c-1]+2*p1[c-1]+p2[c-1]).
REQ-016 For each output: Gy = (p2[c-1]+2*p2[c]+p2[c+1]) - (p0[c-1]+2*p0[c]+p0[c+1]).
REQ-017 Gx and Gy SHALL be computed as 11-bit signed values; mag = |Gx|+|Gy| SHALL be computed unsigned and saturated to 255.
REQ-018 COMPUTE SHALL use one shared kernel instance, evaluating output k in CALC cycle k.
REQ-019 COMPUTE SHALL return result = {mag3, mag2, mag1, mag0}, with mag0 in byte 0.
REQ-020 Opcode 10 CLEAR SHALL zero all six buffer words; done and result 0 SHALL follow 1 cycle after the accept.
REQ-021 Opcode 11 (reserved) SHALL change no state and complete 1 cycle after the accept with result 0.
REQ-022 FSM states SHALL be IDLE, CALC, DONE.
- IDLE -> CALC on an accepted COMPUTE.
- IDLE -> DONE on any other accepted opcode.
- CALC -> DONE after 4 cycles, tracked by a 2-bit counter.
- DONE -> IDLE unconditionally.
REQ-023 done SHALL be 1 only in DONE; COMPUTE accepted at cycle T SHALL assert done at T+5, and other opcodes at T+1.
REQ-024 Buffers SHALL NOT change during CALC; LOAD/CLEAR updates SHALL take effect on the accept edge.
REQ-025 Back-to-back commands SHALL be allowed: a new start is accepted in the IDLE cycle following DONE.

Reset
REQ-026 On reset: state IDLE, counter 0, all buffer words 0, done 0, result 32'd0.
REQ-027 Reset during CALC or DONE SHALL abort the operation; no done SHALL be emitted for the aborted command.
REQ-028 Reset SHALL take priority over a simultaneous start.

Structure
REQ-029 Package sobel_seq_pkg SHALL contain the opcode constants, the FSM state encoding and the saturation constant 8'd255.
REQ-030 The arithmetic SHALL live in one combinational sub-module, sobel_kernel3x3: nine 8-bit pixel inputs, one 8-bit saturated magnitude output.
REQ-031 The top level SHALL contain only the FSM, the counter, the buffers, the window mux and the result packing register.

Verification
REQ-032 Flat image: LOAD all rows twice with 0x64646464, then COMPUTE -> result 0x00000000, done exactly at T+5.
REQ-033 Vertical edge: each row LOAD 0x00000000 then 0xFFFFFFFF, then COMPUTE -> result 0x0000FFFF.
REQ-034 Horizontal gradient: rows 0 and 1 zero, row 2 loaded twice with 0x0A0A0A0A, then COMPUTE -> result 0x28282828.
REQ-035 Wrong iseId, or start asserted during CALC -> no done, buffers unchanged, result stays 0.
REQ-036 Reset asserted at T+2 of a COMPUTE -> no done; a following COMPUTE returns 0x00000000.
REQ-037 CLEAR after loads -> done at T+1 with result 0; a subsequent COMPUTE returns 0x00000000.

Source files
------------

// File: rtl/sobel_seq_pkg.sv
// Shared constants and types for the Sobel window sequencer custom instruction.
// Opcodes, FSM state encoding, saturation limit and a pixel-select helper.
package sobel_seq_pkg;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_COMPUTE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [7:0] SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A window row is {cur, old}; pixel 0 is the low byte of old.
  function automatic logic [7:0] pixel_at(input logic [63:0] row, input logic [2:0] idx);
    return row[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Combinational 3x3 Sobel operator: |Gx|+|Gy| saturated to one byte.
// Pixel pRC is row R (0 = top), column C (0 = left) of the 3x3 neighbourhood.
module sobel_kernel3x3 (
  input  logic [7:0] p00,
  input  logic [7:0] p01,
  input  logic [7:0] p02,
  input  logic [7:0] p10,
  input  logic [7:0] p11,
  input  logic [7:0] p12,
  input  logic [7:0] p20,
  input  logic [7:0] p21,
  input  logic [7:0] p22,
  output logic [7:0] mag
);
  import sobel_seq_pkg::*;

  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic [10:0]        abs_gx, abs_gy;
  logic [11:0]        mag_sum;
  logic [7:0]         unused_center;

  // Each weighted column/row sum is at most 4*255, so 10 bits are enough.
  assign gx_pos = 10'(p02) + 10'({p12, 1'b0}) + 10'(p22);
  assign gx_neg = 10'(p00) + 10'({p10, 1'b0}) + 10'(p20);
  assign gy_pos = 10'(p20) + 10'({p21, 1'b0}) + 10'(p22);
  assign gy_neg = 10'(p00) + 10'({p01, 1'b0}) + 10'(p02);

  assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  assign abs_gx = gx[10] ? $unsigned(-gx) : $unsigned(gx);
  assign abs_gy = gy[10] ? $unsigned(-gy) : $unsigned(gy);

  assign mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
  assign mag     = (mag_sum > {4'd0, SAT_MAX}) ? SAT_MAX : mag_sum[7:0];

  assign unused_center = p11;

endmodule

// File: rtl/sobel_window_sequencer.sv
// Custom-instruction front end: holds a 3x8 pixel window and runs the shared
// Sobel kernel over four centre columns, one per CALC cycle.
module sobel_window_sequencer #(
  parameter logic [7:0] customInstructionId = 8'd24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);
  import sobel_seq_pkg::*;

  state_t      state, state_next;
  logic [1:0]  calc_cnt;
  logic [31:0] old_buf [3];
  logic [31:0] cur_buf [3];
  logic [31:0] mag_reg;
  logic [63:0] win_row [3];
  logic        accept;
  logic [1:0]  opcode, row_sel;
  logic [2:0]  col_base;
  logic [7:0]  kernel_mag;
  logic        unused_cmd_bits;

  assign opcode          = valueA[31:30];
  assign row_sel         = valueA[1:0];
  assign unused_cmd_bits = ^valueA[29:2];
  assign accept          = start && (iseId == customInstructionId) && (state == ST_IDLE);

  for (genvar i = 0; i < 3; i++) begin : g_rows
    assign win_row[i] = {cur_buf[i], old_buf[i]};
  end

  // Output k is centred on pixel 3+k, so its left column is pixel 2+k.
  assign col_base = 3'd2 + {1'b0, calc_cnt};

  sobel_kernel3x3 u_kernel (
    .p00 (pixel_at(win_row[0], col_base)),
    .p01 (pixel_at(win_row[0], col_base + 3'd1)),
    .p02 (pixel_at(win_row[0], col_base + 3'd2)),
    .p10 (pixel_at(win_row[1], col_base)),
    .p11 (pixel_at(win_row[1], col_base + 3'd1)),
    .p12 (pixel_at(win_row[1], col_base + 3'd2)),
    .p20 (pixel_at(win_row[2], col_base)),
    .p21 (pixel_at(win_row[2], col_base + 3'd1)),
    .p22 (pixel_at(win_row[2], col_base + 3'd2)),
    .mag (kernel_mag)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (opcode == OP_COMPUTE) ? ST_CALC : ST_DONE;
      ST_CALC: if (calc_cnt == 2'd3) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done   = (state == ST_DONE);
    result = done ? mag_reg : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      calc_cnt <= 2'd0;
      mag_reg  <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        old_buf[i] <= 32'd0;
        cur_buf[i] <= 32'd0;
      end
    end else begin
      state <= state_next;
      if (accept) begin
        calc_cnt <= 2'd0;
        mag_reg  <= 32'd0;
        for (int i = 0; i < 3; i++) begin
          if (opcode == OP_CLEAR) begin
            old_buf[i] <= 32'd0;
            cur_buf[i] <= 32'd0;
          end else if (opcode == OP_LOAD && row_sel == 2'(i)) begin
            old_buf[i] <= cur_buf[i];
            cur_buf[i] <= valueB;
          end
        end
      end
      // Buffers are frozen here; only the packed result and counter move.
      if (state == ST_CALC) begin
        mag_reg[{calc_cnt, 3'b000} +: 8] <= kernel_mag;
        calc_cnt <= calc_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Self-checking bench for sobel_window_sequencer: directed cases plus random
// command streams checked against a pixel-array reference model.
module tb_sobel_window_sequencer;

  localparam logic [7:0] ID       = 8'd24;
  localparam logic [7:0] WRONG_ID = 8'd25;
  localparam logic [1:0] LOAD = 2'b00, COMPUTE = 2'b01, CLEAR = 2'b10, RSVD = 2'b11;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  iseId;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;
  int pix [3][8];

  always #5 clock = ~clock;

  sobel_window_sequencer #(.customInstructionId(ID)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void modelClear();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) pix[r][i] = 0;
  endfunction

  function automatic void modelCmd(input logic [1:0] op, input int row, input logic [31:0] data);
    if (op == LOAD && row < 3) begin
      for (int i = 0; i < 4; i++) begin
        pix[row][i]     = pix[row][i + 4];
        pix[row][i + 4] = int'((data >> (8 * i)) & 32'hFF);
      end
    end else if (op == CLEAR) begin
      modelClear();
    end
  endfunction

  function automatic logic [31:0] modelCompute();
    logic [31:0] res = 32'd0;
    for (int k = 0; k < 4; k++) begin
      int c = 3 + k;
      int gx = (pix[0][c+1] + 2*pix[1][c+1] + pix[2][c+1]) - (pix[0][c-1] + 2*pix[1][c-1] + pix[2][c-1]);
      int gy = (pix[2][c-1] + 2*pix[2][c] + pix[2][c+1]) - (pix[0][c-1] + 2*pix[0][c] + pix[0][c+1]);
      int m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
      res[8*k +: 8] = 8'(m);
    end
    return res;
  endfunction

  // Drives one start pulse; returns #1 after the edge that samples it.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] row,
                               input logic [31:0] data, input logic [7:0] id);
    @(negedge clock);
    start  = 1'b1;
    iseId  = id;
    valueA = {op, 28'd0, row};
    valueB = data;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int startLat, input int expLat,
                             input logic [31:0] expRes);
    int          lat   = startLat;
    logic [31:0] stray = 32'd0;
    while (done !== 1'b1 && lat < 12) begin
      if (result !== 32'd0) stray = result;
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(expLat));
    check({tag, "_result"}, result, expRes);
    check({tag, "_result_before_done"}, stray, 32'd0);
    @(posedge clock);
    #1;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  task automatic expectSilence(input string tag, input int cycles);
    logic        sawDone = 1'b0;
    logic [31:0] badRes  = 32'd0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (done !== 1'b0) sawDone = 1'b1;
      if (result !== 32'd0) badRes = result;
    end
    check({tag, "_no_done"}, {31'd0, sawDone}, 32'd0);
    check({tag, "_result_zero"}, badRes, 32'd0);
  endtask

  task automatic doCmd(input logic [1:0] op, input logic [1:0] row,
                       input logic [31:0] data, input string tag);
    logic [31:0] exp = (op == COMPUTE) ? modelCompute() : 32'd0;
    applyStimulus(op, row, data, ID);
    modelCmd(op, int'(row), data);
    checkOutput(tag, 1, (op == COMPUTE) ? 5 : 1, exp);
  endtask

  task automatic doCompute(input string tag, input logic [31:0] exp);
    applyStimulus(COMPUTE, 2'd0, 32'd0, ID);
    checkOutput(tag, 1, 5, exp);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    iseId  = 8'd0;
    valueA = 32'd0;
    valueB = 32'd0;
    modelClear();
    repeat (3) @(posedge clock);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_done", {31'd0, done}, 32'd0);
    check("post_reset_result", result, 32'd0);

    $display("[TB] flat image");
    for (int pass = 0; pass < 2; pass++)
      for (int r = 0; r < 3; r++) doCmd(LOAD, 2'(r), 32'h64646464, "flat_load");
    doCompute("flat_compute", 32'h00000000);

    $display("[TB] vertical edge");
    doCmd(CLEAR, 2'd0, 32'd0, "clear_a");
    for (int r = 0; r < 3; r++) begin
      doCmd(LOAD, 2'(r), 32'h00000000, "vedge_load_lo");
      doCmd(LOAD, 2'(r), 32'hFFFFFFFF, "vedge_load_hi");
    end
    doCompute("vedge_compute", 32'h0000FFFF);

    $display("[TB] horizontal gradient");
    doCmd(CLEAR, 2'd0, 32'd0, "clear_b");
    doCmd(LOAD, 2'd2, 32'h0A0A0A0A, "hgrad_load");
    doCmd(LOAD, 2'd2, 32'h0A0A0A0A, "hgrad_load");
    doCompute("hgrad_compute", 32'h28282828);

    $display("[TB] ignored starts");
    applyStimulus(LOAD, 2'd0, 32'hDEADBEEF, WRONG_ID);
    expectSilence("wrong_id", 8);
    doCompute("after_wrong_id", 32'h28282828);
    doCmd(LOAD, 2'd3, 32'hFFFFFFFF, "load_row3");
    doCompute("after_row3", 32'h28282828);
    applyStimulus(COMPUTE, 2'd0, 32'd0, ID);
    @(negedge clock);
    start  = 1'b1;
    iseId  = ID;
    valueA = {LOAD, 28'd0, 2'd2};
    valueB = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("start_in_calc", 2, 5, 32'h28282828);
    expectSilence("start_in_calc_after", 4);
    doCompute("after_start_in_calc", 32'h28282828);
    doCmd(RSVD, 2'd1, 32'h12345678, "reserved");
    doCompute("after_reserved", 32'h28282828);

    $display("[TB] reset during compute");
    applyStimulus(COMPUTE, 2'd0, 32'd0, ID);
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelClear();
    expectSilence("reset_abort", 8);
    doCompute("after_abort", 32'h00000000);

    $display("[TB] reset with start");
    doCmd(LOAD, 2'd0, 32'hFFFFFFFF, "prio_load");
    @(negedge clock);
    reset  = 1'b1;
    start  = 1'b1;
    iseId  = ID;
    valueA = {LOAD, 28'd0, 2'd1};
    valueB = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    modelClear();
    expectSilence("reset_priority", 4);
    doCompute("after_priority", 32'h00000000);

    $display("[TB] clear after loads");
    doCmd(LOAD, 2'd0, 32'h11223344, "pre_clear_load");
    doCmd(LOAD, 2'd1, 32'hFF00FF00, "pre_clear_load");
    doCmd(LOAD, 2'd2, 32'h80808080, "pre_clear_load");
    doCmd(CLEAR, 2'd0, 32'd0, "clear_c");
    doCompute("after_clear", 32'h00000000);

    $display("[TB] random commands");
    for (int n = 0; n < 80; n++) begin
      int          sel  = int'($urandom_range(0, 9));
      logic [1:0]  op   = (sel <= 5) ? LOAD : (sel <= 7) ? COMPUTE : (sel == 8) ? CLEAR : RSVD;
      logic [1:0]  row  = 2'($urandom_range(0, 3));
      logic [31:0] data = $urandom;
      if ($urandom_range(0, 1) == 0) data = data & 32'h3F3F3F3F;
      doCmd(op, row, data, "random");
    end
    doCompute("random_final", modelCompute());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
